// File: rtl/sdram_access_arbiter.sv
// sdram_access_arbiter: shares the SDRAM command sequencer between the
// read path, the write path and periodic auto-refresh.
module sdram_access_arbiter #(
    parameter int REF_INTERVAL = 750,
    parameter int MAX_PENDING  = 4,
    parameter int CNT_W        = 10
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       init_done,
    input  logic       rd_req,
    input  logic       rd_done,
    input  logic       wr_req,
    input  logic       wr_done,
    input  logic       ref_done,
    output logic       rd_gnt,
    output logic       wr_gnt,
    output logic       ref_gnt,
    output logic [2:0] ref_pending,
    output logic       ref_overflow,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_RD,
        GNT_WR,
        GNT_REF
    } state_t;

    typedef enum logic {
        SRV_RD,
        SRV_WR
    } served_t;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(REF_INTERVAL - 1);
    localparam logic [2:0]       PEND_MAX   = 3'(MAX_PENDING);

    state_t           state;
    state_t           state_nxt;
    served_t          last_served;
    served_t          last_served_nxt;
    logic [CNT_W-1:0] timer;
    logic             tick;
    logic             ref_dec;
    logic             urgent;

    assign tick    = init_done && (timer == TIMER_LAST);
    assign ref_dec = (state == GNT_REF) && ref_done;
    assign urgent  = (ref_pending == PEND_MAX);

    // Refresh interval timer: parked at zero until the SDRAM is initialised.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            timer <= '0;
        end else if (!init_done || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + CNT_W'(1);
        end
    end

    // Postponed-refresh count; a tick that finds the counter full is lost.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ref_pending  <= '0;
            ref_overflow <= 1'b0;
        end else if (tick && !ref_dec) begin
            if (urgent) begin
                ref_overflow <= 1'b1;
            end else begin
                ref_pending <= ref_pending + 3'd1;
            end
        end else if (ref_dec && !tick && (ref_pending != '0)) begin
            ref_pending <= ref_pending - 3'd1;
        end
    end

    // State and round-robin history registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= IDLE;
            last_served <= SRV_WR;
        end else begin
            state       <= state_nxt;
            last_served <= last_served_nxt;
        end
    end

    // Arbitration in IDLE; each grant state waits for its own done pulse.
    always_comb begin
        state_nxt       = state;
        last_served_nxt = last_served;
        unique case (state)
            IDLE: begin
                if (init_done) begin
                    if (urgent) begin
                        state_nxt = GNT_REF;
                    end else if (rd_req && wr_req) begin
                        state_nxt = (last_served == SRV_WR) ? GNT_RD : GNT_WR;
                    end else if (rd_req) begin
                        state_nxt = GNT_RD;
                    end else if (wr_req) begin
                        state_nxt = GNT_WR;
                    end else if (ref_pending != '0) begin
                        state_nxt = GNT_REF;
                    end
                end
            end
            GNT_RD: begin
                if (rd_done) begin
                    state_nxt       = IDLE;
                    last_served_nxt = SRV_RD;
                end
            end
            GNT_WR: begin
                if (wr_done) begin
                    state_nxt       = IDLE;
                    last_served_nxt = SRV_WR;
                end
            end
            GNT_REF: begin
                if (ref_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered one-hot grants, loaded from the next state.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rd_gnt  <= 1'b0;
            wr_gnt  <= 1'b0;
            ref_gnt <= 1'b0;
        end else begin
            rd_gnt  <= (state_nxt == GNT_RD);
            wr_gnt  <= (state_nxt == GNT_WR);
            ref_gnt <= (state_nxt == GNT_REF);
        end
    end

    assign busy = rd_gnt | wr_gnt | ref_gnt;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// tb_sdram_access_arbiter: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the arbiter.
module tb_sdram_access_arbiter;

    localparam int RI = 750;
    localparam int MP = 4;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic       init_done;
    logic       rd_req;
    logic       rd_done;
    logic       wr_req;
    logic       wr_done;
    logic       ref_done;
    logic       rd_gnt;
    logic       wr_gnt;
    logic       ref_gnt;
    logic [2:0] ref_pending;
    logic       ref_overflow;
    logic       busy;

    int checks = 0;
    int passed = 0;

    // model: owner 0 none, 1 read, 2 write, 3 refresh
    int m_own;
    int m_pend;
    bit m_ovf;
    bit m_last_rd;
    int m_age;

    sdram_access_arbiter #(
        .REF_INTERVAL(RI),
        .MAX_PENDING (MP),
        .CNT_W       (10)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .init_done   (init_done),
        .rd_req      (rd_req),
        .rd_done     (rd_done),
        .wr_req      (wr_req),
        .wr_done     (wr_done),
        .ref_done    (ref_done),
        .rd_gnt      (rd_gnt),
        .wr_gnt      (wr_gnt),
        .ref_gnt     (ref_gnt),
        .ref_pending (ref_pending),
        .ref_overflow(ref_overflow),
        .busy        (busy)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_own     = 0;
        m_pend    = 0;
        m_ovf     = 0;
        m_last_rd = 0;
        m_age     = 0;
    endtask

    task automatic m_step();
        bit tick;
        bit dec;
        int nxt;
        tick = init_done && ((m_age % RI) == RI - 1);
        dec  = (m_own == 3) && ref_done;
        nxt  = m_own;
        case (m_own)
            0: if (init_done) begin
                if (m_pend == MP) nxt = 3;
                else if (rd_req && wr_req) nxt = m_last_rd ? 2 : 1;
                else if (rd_req) nxt = 1;
                else if (wr_req) nxt = 2;
                else if (m_pend > 0) nxt = 3;
            end
            1: if (rd_done) begin nxt = 0; m_last_rd = 1; end
            2: if (wr_done) begin nxt = 0; m_last_rd = 0; end
            default: if (ref_done) nxt = 0;
        endcase
        m_pend = m_pend + (tick ? 1 : 0) - (dec ? 1 : 0);
        if (m_pend > MP) begin
            m_pend = MP;
            m_ovf  = 1;
        end
        m_age = init_done ? m_age + 1 : 0;
        m_own = nxt;
    endtask

    task automatic compare();
        check("grant", {rd_gnt, wr_gnt, ref_gnt},
              {m_own == 1, m_own == 2, m_own == 3});
        check("busy", busy, m_own != 0);
        check("pending", ref_pending, m_pend);
        check("overflow", ref_overflow, m_ovf);
    endtask

    task automatic cycle();
        @(posedge HCLK);
        if (HRESET) m_reset();
        else m_step();
        #1;
        compare();
        rd_done  = 0;
        wr_done  = 0;
        ref_done = 0;
    endtask

    task automatic do_reset();
        HRESET    = 1;
        init_done = 0;
        rd_req    = 0;
        wr_req    = 0;
        cycle();
        HRESET = 0;
    endtask

    initial begin
        int n;
        int lat;
        int prev_own;
        HRESET    = 1;
        init_done = 0;
        rd_req    = 0;
        wr_req    = 0;
        rd_done   = 0;
        wr_done   = 0;
        ref_done  = 0;
        m_reset();
        repeat (3) cycle();
        check("rst_pend", ref_pending, 0);
        check("rst_outs", {rd_gnt, wr_gnt, ref_gnt, busy, ref_overflow}, 0);

        // reset during a read grant, then long pre-init period
        HRESET    = 0;
        init_done = 1;
        rd_req    = 1;
        cycle();
        check("t1_rd", rd_gnt, 1);
        cycle();
        HRESET = 1;
        #1;
        check("t1_async", {rd_gnt, busy}, 0);
        m_reset();
        cycle();
        HRESET    = 0;
        init_done = 0;
        repeat (2000) cycle();
        check("t1_noinit_gnt", rd_gnt, 0);
        check("t1_noinit_pend", ref_pending, 0);

        // single read
        init_done = 1;
        cycle();
        check("t2_gnt", rd_gnt, 1);
        repeat (3) cycle();
        check("t2_hold", rd_gnt, 1);
        rd_done = 1;
        rd_req  = 0;
        cycle();
        check("t2_release", rd_gnt, 0);

        // round-robin
        do_reset();
        init_done = 1;
        rd_req    = 1;
        wr_req    = 1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t3_order", {rd_gnt, wr_gnt}, (k % 2 == 0) ? 2 : 1);
            cycle();
            cycle();
            if (k % 2 == 0) rd_done = 1;
            else wr_done = 1;
            cycle();
            check("t3_gap", busy, 0);
        end
        rd_req = 0;
        wr_req = 0;

        // refresh on idle bus
        do_reset();
        init_done = 1;
        repeat (RI) cycle();
        check("t4_pend", ref_pending, 1);
        check("t4_not_yet", ref_gnt, 0);
        cycle();
        check("t4_gnt", ref_gnt, 1);
        ref_done = 1;
        cycle();
        check("t4_clr", ref_pending, 0);
        check("t4_drop", ref_gnt, 0);

        // urgent refresh and overflow
        do_reset();
        init_done = 1;
        rd_req    = 1;
        cycle();
        repeat (4 * RI - 1) cycle();
        check("t5_pend4", ref_pending, 4);
        check("t5_no_ovf", ref_overflow, 0);
        repeat (RI) cycle();
        check("t5_ovf", ref_overflow, 1);
        check("t5_stay4", ref_pending, 4);
        check("t5_still_rd", rd_gnt, 1);
        wr_req  = 1;
        rd_req  = 0;
        rd_done = 1;
        cycle();
        check("t5_gap", busy, 0);
        cycle();
        check("t5_ref_first", {wr_gnt, ref_gnt}, 1);
        ref_done = 1;
        cycle();
        check("t5_pend3", ref_pending, 3);
        cycle();
        check("t5_wr_next", wr_gnt, 1);
        wr_done = 1;
        wr_req  = 0;
        cycle();

        // refresh done coincident with a tick, stray done
        do_reset();
        init_done = 1;
        rd_req    = 1;
        repeat (2 * RI) cycle();
        check("t6_pend2", ref_pending, 2);
        rd_req  = 0;
        rd_done = 1;
        cycle();
        cycle();
        check("t6_ref", ref_gnt, 1);
        n = 0;
        while ((m_age % RI) != RI - 1 && n < 800) begin
            cycle();
            n++;
        end
        if (n >= 800) check("t6_timeout", 0, 1);
        ref_done = 1;
        cycle();
        check("t6_same", ref_pending, 2);
        wr_done = 1;
        cycle();
        check("t6_stray_pend", ref_pending, 2);
        check("t6_stray_wr", wr_gnt, 0);

        // random traffic
        do_reset();
        init_done = 1;
        lat       = 0;
        prev_own  = 0;
        for (int i = 0; i < 20000; i++) begin
            if (m_own != prev_own) begin
                if ($urandom_range(0, 19) == 0) lat = $urandom_range(700, 2500);
                else lat = $urandom_range(0, 5);
            end
            prev_own = m_own;
            if (m_own != 0) begin
                if (lat == 0) begin
                    case (m_own)
                        1: begin rd_done = 1; rd_req = 0; end
                        2: begin wr_done = 1; wr_req = 0; end
                        default: ref_done = 1;
                    endcase
                end else begin
                    lat--;
                end
            end
            if (m_own != 1) begin
                if (!rd_req) rd_req = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 19) == 0) rd_req = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                rd_req = 0;
            end
            if (m_own != 2) begin
                if (!wr_req) wr_req = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 19) == 0) wr_req = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                wr_req = 0;
            end
            if (m_own != 1 && $urandom_range(0, 29) == 0) rd_done = 1;
            if (m_own != 2 && $urandom_range(0, 29) == 0) wr_done = 1;
            if (m_own != 3 && $urandom_range(0, 29) == 0) ref_done = 1;
            if (init_done && $urandom_range(0, 999) == 0) init_done = 0;
            else if (!init_done && $urandom_range(0, 9) == 0) init_done = 1;
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
